regfile_wb_arbiter: RTL and testbench

//  Shares the register file's single write port between two writeback requesters:
//  A = ALU result, B = load data. Uses 2-way round-robin arbitration over valid/ready.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/rr_arb2.sv | 25 ++
 rtl/regfile_wb_arbiter.sv | 100 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package regfile_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned ZERO_REG = 0;

  // Round-robin pointer value: which requester won the most recent transfer.
  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } gnt_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. gnt[0] = requester A, gnt[1] = requester B.
// On a tie, the requester that did not win last (ptr) is granted.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic [1:0] req,
  input  logic       en,
  input  gnt_e       ptr,
  output logic [1:0] gnt
);

  // Combinational grant; nothing is granted while disabled.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (ptr == GNT_A) ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between the ALU (A) and load (B)
// writeback paths. The granted write is staged for one cycle, then driven onto the
// write port; while staged it is bypassed onto both read ports.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W    = regfile_pkg::DATA_W,
  parameter int unsigned ADDR_W    = regfile_pkg::ADDR_W,
  parameter int unsigned ZERO_DROP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_dest,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_dest,
  input  logic [DATA_W-1:0] b_data,
  input  logic              hold,
  output logic              reg_write_en,
  output logic [ADDR_W-1:0] reg_write_dest,
  output logic [DATA_W-1:0] reg_write_data,
  input  logic [ADDR_W-1:0] rd_addr_1,
  input  logic [ADDR_W-1:0] rd_addr_2,
  input  logic [DATA_W-1:0] rf_rd_data_1,
  input  logic [DATA_W-1:0] rf_rd_data_2,
  output logic [DATA_W-1:0] rd_data_1,
  output logic [DATA_W-1:0] rd_data_2,
  output logic              last_gnt
);

  import regfile_pkg::*;

  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZERO_REG);

  logic [1:0]        gnt;
  gnt_e              last_gnt_q, last_gnt_d;
  logic              wb_valid_q, wb_valid_d;
  logic [ADDR_W-1:0] wb_dest_q, wb_dest_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;

  rr_arb2 u_arb (
    .req ({b_valid, a_valid}),
    .en  (!hold),
    .ptr (last_gnt_q),
    .gnt (gnt)
  );

  assign a_ready = gnt[0];
  assign b_ready = gnt[1];

  // Next state: load the stage on a transfer, otherwise let it drain.
  always_comb begin
    last_gnt_d = last_gnt_q;
    wb_valid_d = |gnt;
    wb_dest_d  = wb_dest_q;
    wb_data_d  = wb_data_q;
    if (gnt[1]) begin
      last_gnt_d = GNT_B;
      wb_dest_d  = b_dest;
      wb_data_d  = b_data;
    end else if (gnt[0]) begin
      last_gnt_d = GNT_A;
      wb_dest_d  = a_dest;
      wb_data_d  = a_data;
    end
  end

  // Stage register and round-robin pointer; pointer resets to B so A wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q <= GNT_B;
      wb_valid_q <= 1'b0;
      wb_dest_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      wb_valid_q <= wb_valid_d;
      wb_dest_q  <= wb_dest_d;
      wb_data_q  <= wb_data_d;
    end
  end

  // Write port drive and read bypass; R0 writes are swallowed when ZERO_DROP is set.
  always_comb begin
    reg_write_en   = wb_valid_q && !((ZERO_DROP != 0) && (wb_dest_q == ZeroAddr));
    reg_write_dest = wb_dest_q;
    reg_write_data = wb_data_q;
    last_gnt       = last_gnt_q;
    rd_data_1      = rf_rd_data_1;
    rd_data_2      = rf_rd_data_2;
    if (reg_write_en && (wb_dest_q == rd_addr_1) && (rd_addr_1 != ZeroAddr)) begin
      rd_data_1 = wb_data_q;
    end
    if (reg_write_en && (wb_dest_q == rd_addr_2) && (rd_addr_2 != ZeroAddr)) begin
      rd_data_2 = wb_data_q;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a small register-file model behind it.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        a_valid, b_valid, a_ready, b_ready, hold;
  logic [3:0]  a_dest, b_dest;
  logic [15:0] a_data, b_data;
  logic        reg_write_en;
  logic [3:0]  reg_write_dest;
  logic [15:0] reg_write_data;
  logic [3:0]  rd_addr_1, rd_addr_2;
  logic [15:0] rf_rd_data_1, rf_rd_data_2, rd_data_1, rd_data_2;
  logic        last_gnt;

  logic [15:0] rf [16];
  logic        ovr1;
  logic [15:0] ovr1_val;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .a_valid        (a_valid),
    .a_ready        (a_ready),
    .a_dest         (a_dest),
    .a_data         (a_data),
    .b_valid        (b_valid),
    .b_ready        (b_ready),
    .b_dest         (b_dest),
    .b_data         (b_data),
    .hold           (hold),
    .reg_write_en   (reg_write_en),
    .reg_write_dest (reg_write_dest),
    .reg_write_data (reg_write_data),
    .rd_addr_1      (rd_addr_1),
    .rd_addr_2      (rd_addr_2),
    .rf_rd_data_1   (rf_rd_data_1),
    .rf_rd_data_2   (rf_rd_data_2),
    .rd_data_1      (rd_data_1),
    .rd_data_2      (rd_data_2),
    .last_gnt       (last_gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: commits the write port on the rising edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else if (reg_write_en) begin
      rf[reg_write_dest] <= reg_write_data;
    end
  end

  assign rf_rd_data_1 = ovr1 ? ovr1_val : rf[rd_addr_1];
  assign rf_rd_data_2 = rf[rd_addr_2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; hold = 1'b0;
    a_valid = 1'b0; a_dest = '0; a_data = '0;
    b_valid = 1'b0; b_dest = '0; b_data = '0;
    rd_addr_1 = '0; rd_addr_2 = '0; ovr1 = 1'b0; ovr1_val = '0;
    tick(); tick();
    chk("rst_last_gnt", last_gnt, 1);
    chk("rst_wen", reg_write_en, 0);
    rst_n = 1'b1;

    // 1: reset while a write sits in the stage register
    a_valid = 1'b1; a_dest = 4'd9; a_data = 16'h1111;
    tick();
    a_valid = 1'b0;
    chk("t1_inflight_wen", reg_write_en, 1);
    chk("t1_inflight_last", last_gnt, 0);
    rst_n = 1'b0;
    #1;
    chk("t1_async_wen", reg_write_en, 0);
    chk("t1_async_dest", reg_write_dest, 0);
    chk("t1_async_data", reg_write_data, 0);
    chk("t1_async_last", last_gnt, 1);
    rst_n = 1'b1;
    tick();
    chk("t1_post_wen", reg_write_en, 0);
    chk("t1_r9_untouched", rf[9], 16'h0000);

    // 2: single requester
    a_valid = 1'b1; a_dest = 4'd3; a_data = 16'h1234;
    #1;
    chk("t2_a_ready", a_ready, 1);
    chk("t2_b_ready", b_ready, 0);
    tick();
    a_valid = 1'b0;
    chk("t2_wen", reg_write_en, 1);
    chk("t2_dest", reg_write_dest, 3);
    chk("t2_data", reg_write_data, 16'h1234);
    tick();
    chk("t2_drained", reg_write_en, 0);
    chk("t2_r3", rf[3], 16'h1234);

    // 3: dual continuous requests from reset -> A,B,A,B
    rst_n = 1'b0; #1; rst_n = 1'b1;
    a_valid = 1'b1; a_dest = 4'd1; a_data = 16'hA001;
    b_valid = 1'b1; b_dest = 4'd2; b_data = 16'hB002;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t3_gnt%0d", i), {b_ready, a_ready}, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i > 0) chk($sformatf("t3_wdest%0d", i), reg_write_dest, (i % 2 == 1) ? 1 : 2);
      tick();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    chk("t3_last_wdest", reg_write_dest, 2);
    chk("t3_last_wdata", reg_write_data, 16'hB002);
    chk("t3_last_gnt", last_gnt, 1);
    tick();

    // 4: same destination from both requesters; later grant wins
    a_valid = 1'b1; a_dest = 4'd5; a_data = 16'h00AA;
    b_valid = 1'b1; b_dest = 4'd5; b_data = 16'h00BB;
    #1;
    chk("t4_a_first", {b_ready, a_ready}, 2'b01);
    tick();
    a_valid = 1'b0;
    #1;
    chk("t4_b_second", b_ready, 1);
    chk("t4_w1_data", reg_write_data, 16'h00AA);
    tick();
    b_valid = 1'b0;
    chk("t4_w2_data", reg_write_data, 16'h00BB);
    tick();
    chk("t4_r5_final", rf[5], 16'h00BB);

    // 5: bypass of the staged write
    a_valid = 1'b1; a_dest = 4'd7; a_data = 16'hBEEF;
    tick();
    a_valid = 1'b0;
    ovr1 = 1'b1; ovr1_val = 16'h00FF; rd_addr_1 = 4'd7; rd_addr_2 = 4'd0;
    #1;
    chk("t5_bypass1", rd_data_1, 16'hBEEF);
    chk("t5_rd2_zero", rd_data_2, 16'h0000);
    rd_addr_1 = 4'd6;
    #1;
    chk("t5_nomatch", rd_data_1, 16'h00FF);
    rd_addr_1 = 4'd7; rd_addr_2 = 4'd7;
    #1;
    chk("t5_bypass2", rd_data_2, 16'hBEEF);
    tick();
    chk("t5_after_drain", rd_data_1, 16'h00FF);
    ovr1 = 1'b0; rd_addr_1 = 4'd0; rd_addr_2 = 4'd0;

    // 6a: R0 writes are accepted but never issued
    a_valid = 1'b1; a_dest = 4'd0; a_data = 16'hDEAD;
    #1;
    chk("t6_r0_ready", a_ready, 1);
    tick();
    a_valid = 1'b0;
    chk("t6_r0_wen", reg_write_en, 0);
    chk("t6_r0_read", rd_data_2, 16'h0000);
    tick();

    // 6b: hold blocks grants but not draining of the stage register
    a_valid = 1'b1; a_dest = 4'd8; a_data = 16'h8888;
    tick();
    a_valid = 1'b0;
    hold = 1'b1; b_valid = 1'b1; b_dest = 4'd4; b_data = 16'h4444;
    #1;
    chk("t6_drain_wen", reg_write_en, 1);
    chk("t6_drain_dest", reg_write_dest, 8);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("t6_hold_b_ready%0d", i), b_ready, 0);
      tick();
      chk($sformatf("t6_hold_wen%0d", i), reg_write_en, 0);
      chk($sformatf("t6_hold_last%0d", i), last_gnt, 0);
    end
    hold = 1'b0;
    #1;
    chk("t6_release_ready", b_ready, 1);
    tick();
    b_valid = 1'b0;
    chk("t6_release_wen", reg_write_en, 1);
    chk("t6_release_dest", reg_write_dest, 4);
    chk("t6_release_last", last_gnt, 1);
    tick();
    chk("t6_r4", rf[4], 16'h4444);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
